pal_pad_scheduler: RTL and testbench

- Sequences PAL line padding for the VDG video path.
- Each field, after a programmable number of VDG rows following field sync, it stalls the VDG clock for a programmable number of synthetic line periods.
- While stalled it generates synthetic horizontal sync pulses and a luma blank.
- It drives the clock-gate, sync-merge and luma-control points of the PAL video padding stage. In NTSC format it is transparent.

---
 rtl/pal_pad_scheduler.sv | 139 +++++++++++++
 tb/tb_pal_pad_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pal_pad_scheduler.sv
// PAL line-padding sequencer: after a programmable number of VDG rows following field sync,
// holds the VDG clock for a fixed number of synthetic lines with generated sync and luma blank.
module pal_pad_scheduler #(
    parameter int unsigned DELAY_LINES = 24,
    parameter int unsigned PAD_LINES   = 25,
    parameter int unsigned LINE_CLKS   = 227,
    parameter int unsigned HS_WIDTH    = 17,
    localparam int unsigned PLW = (PAD_LINES > 1) ? $clog2(PAD_LINES) : 1
) (
    input  logic           VCLK,
    input  logic           RST,
    input  logic           Format,
    input  logic           HSb,
    input  logic           FSb,
    output logic           CLK_EN,
    output logic           PAD_HS,
    output logic           LUMA_BLANK,
    output logic [PLW-1:0] PAD_LINE,
    output logic           OVERRUN
);

    localparam int unsigned RW = (DELAY_LINES > 1) ? $clog2(DELAY_LINES) : 1;
    localparam int unsigned TW = $clog2(LINE_CLKS);

    localparam logic [RW-1:0]  RowLast = RW'((DELAY_LINES > 0) ? DELAY_LINES - 1 : 0);
    localparam logic [TW-1:0]  TmrLast = TW'(LINE_CLKS - 1);
    localparam logic [TW-1:0]  HsEnd   = TW'(HS_WIDTH);
    localparam logic [PLW-1:0] PadLast = PLW'(PAD_LINES - 1);

    typedef enum logic [1:0] {StWaitFs, StDelay, StPad} state_e;

    state_e         state_q, state_d;
    logic           hs_cur_q, hs_prev_q, fs_cur_q, fs_prev_q;
    logic           hs_fall, fs_fall;
    logic [RW-1:0]  row_cnt_q, row_cnt_d;
    logic [TW-1:0]  line_tmr_q, line_tmr_d;
    logic [PLW-1:0] pad_line_q, pad_line_d;

    logic           clk_en_d, pad_hs_d, luma_blank_d, overrun_d;
    logic [PLW-1:0] pad_line_out_d;

    assign hs_fall = hs_prev_q & ~hs_cur_q;
    assign fs_fall = fs_prev_q & ~fs_cur_q;

    always_ff @(posedge VCLK) begin
        if (RST) begin
            state_q    <= StWaitFs;
            hs_cur_q   <= 1'b1;
            hs_prev_q  <= 1'b1;
            fs_cur_q   <= 1'b1;
            fs_prev_q  <= 1'b1;
            row_cnt_q  <= '0;
            line_tmr_q <= '0;
            pad_line_q <= '0;
            CLK_EN     <= 1'b1;
            PAD_HS     <= 1'b0;
            LUMA_BLANK <= 1'b0;
            PAD_LINE   <= '0;
            OVERRUN    <= 1'b0;
        end else begin
            state_q    <= state_d;
            hs_cur_q   <= HSb;
            hs_prev_q  <= hs_cur_q;
            fs_cur_q   <= FSb;
            fs_prev_q  <= fs_cur_q;
            row_cnt_q  <= row_cnt_d;
            line_tmr_q <= line_tmr_d;
            pad_line_q <= pad_line_d;
            CLK_EN     <= clk_en_d;
            PAD_HS     <= pad_hs_d;
            LUMA_BLANK <= luma_blank_d;
            PAD_LINE   <= pad_line_out_d;
            OVERRUN    <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        row_cnt_d  = row_cnt_q;
        line_tmr_d = line_tmr_q;
        pad_line_d = pad_line_q;
        if (Format) begin
            // NTSC bypass aborts anything in flight and ignores sync edges
            state_d    = StWaitFs;
            row_cnt_d  = '0;
            line_tmr_d = '0;
            pad_line_d = '0;
        end else begin
            unique case (state_q)
                StWaitFs: begin
                    if (fs_fall) begin
                        row_cnt_d  = '0;
                        line_tmr_d = '0;
                        pad_line_d = '0;
                        state_d    = (DELAY_LINES == 0) ? StPad : StDelay;
                    end
                end
                StDelay: begin
                    if (fs_fall) begin
                        row_cnt_d = '0;
                    end else if (hs_fall) begin
                        if (row_cnt_q == RowLast) begin
                            state_d    = StPad;
                            row_cnt_d  = '0;
                            line_tmr_d = '0;
                            pad_line_d = '0;
                        end else begin
                            row_cnt_d = row_cnt_q + 1'b1;
                        end
                    end
                end
                StPad: begin
                    if (line_tmr_q == TmrLast) begin
                        line_tmr_d = '0;
                        if (pad_line_q == PadLast) begin
                            state_d    = StWaitFs;
                            pad_line_d = '0;
                        end else begin
                            pad_line_d = pad_line_q + 1'b1;
                        end
                    end else begin
                        line_tmr_d = line_tmr_q + 1'b1;
                    end
                end
                default: state_d = StWaitFs;
            endcase
        end
    end

    // Outputs are registered from next-state values so they line up with the state register
    always_comb begin
        clk_en_d       = (state_d != StPad);
        luma_blank_d   = (state_d == StPad);
        pad_hs_d       = (state_d == StPad) && (line_tmr_d < HsEnd);
        pad_line_out_d = (state_d == StPad) ? pad_line_d : '0;
        overrun_d      = OVERRUN | (!Format && (state_q == StPad) && fs_fall);
    end

endmodule

// File: tb/tb_pal_pad_scheduler.sv
// Directed bench for pal_pad_scheduler: default PAL instance plus a short-parameter instance.
module tb_pal_pad_scheduler;

    logic       VCLK;
    logic       RST, Format, HSb, FSb;
    logic       CLK_EN, PAD_HS, LUMA_BLANK, OVERRUN;
    logic [4:0] PAD_LINE;

    logic       rst6, fmt6, hs6, fs6;
    logic       clk_en6, pad_hs6, luma6, ovr6;
    logic [0:0] pad_line6;

    int checks;
    int failures;

    pal_pad_scheduler dut (
        .VCLK(VCLK), .RST(RST), .Format(Format), .HSb(HSb), .FSb(FSb),
        .CLK_EN(CLK_EN), .PAD_HS(PAD_HS), .LUMA_BLANK(LUMA_BLANK),
        .PAD_LINE(PAD_LINE), .OVERRUN(OVERRUN)
    );

    pal_pad_scheduler #(
        .DELAY_LINES(0), .PAD_LINES(1), .LINE_CLKS(20), .HS_WIDTH(3)
    ) dut6 (
        .VCLK(VCLK), .RST(rst6), .Format(fmt6), .HSb(hs6), .FSb(fs6),
        .CLK_EN(clk_en6), .PAD_HS(pad_hs6), .LUMA_BLANK(luma6),
        .PAD_LINE(pad_line6), .OVERRUN(ovr6)
    );

    initial VCLK = 1'b0;
    always #5 VCLK = ~VCLK;

    task automatic tick();
        @(posedge VCLK);
        #1;
    endtask

    task automatic step(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic hs_pulse();
        HSb = 1'b0;
        tick();
        HSb = 1'b1;
        tick();
    endtask

    task automatic fs_pulse();
        FSb = 1'b0;
        tick();
        FSb = 1'b1;
        tick();
    endtask

    // Walks a whole padding interval from its first cycle, checking each cycle's sync/line
    task automatic pad_run(input int fs_at, output int cycles, output int bad);
        cycles = 0;
        bad    = 0;
        while (CLK_EN === 1'b0 && cycles < 6000) begin
            if (PAD_HS !== ((cycles % 227) < 17) || PAD_LINE !== 5'(cycles / 227) ||
                LUMA_BLANK !== 1'b1)
                bad++;
            FSb = (cycles == fs_at) ? 1'b0 : 1'b1;
            cycles++;
            tick();
        end
        FSb = 1'b1;
    endtask

    initial begin
        int cyc, bad, hs_cnt;
        checks   = 0;
        failures = 0;
        RST = 1'b1; Format = 1'b0; HSb = 1'b1; FSb = 1'b1;
        rst6 = 1'b1; fmt6 = 1'b0; hs6 = 1'b1; fs6 = 1'b1;
        step(2);
        chk("rst_clk_en", 32'(CLK_EN), 1);
        chk("rst_pad_hs", 32'(PAD_HS), 0);
        chk("rst_luma", 32'(LUMA_BLANK), 0);
        chk("rst_pad_line", 32'(PAD_LINE), 0);
        chk("rst_overrun", 32'(OVERRUN), 0);
        RST = 1'b0;
        rst6 = 1'b0;
        tick();

        // 1: default PAL padding
        fs_pulse();
        repeat (23) hs_pulse();
        chk("t1_clk_en_before", 32'(CLK_EN), 1);
        hs_pulse();
        chk("t1_clk_en_start", 32'(CLK_EN), 0);
        chk("t1_pad_hs_start", 32'(PAD_HS), 1);
        pad_run(-1, cyc, bad);
        chk("t1_pad_cycles", 32'(cyc), 5675);
        chk("t1_pattern_bad", 32'(bad), 0);
        chk("t1_clk_en_after", 32'(CLK_EN), 1);
        chk("t1_luma_after", 32'(LUMA_BLANK), 0);
        chk("t1_pad_hs_after", 32'(PAD_HS), 0);
        chk("t1_pad_line_after", 32'(PAD_LINE), 0);
        chk("t1_overrun", 32'(OVERRUN), 0);

        // 2: NTSC bypass
        Format = 1'b1;
        tick();
        fs_pulse();
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            hs_pulse();
            if (CLK_EN !== 1'b1 || PAD_HS !== 1'b0 || LUMA_BLANK !== 1'b0) bad++;
        end
        chk("t2_ntsc_bad", 32'(bad), 0);
        Format = 1'b0;
        tick();

        // 3: simultaneous FS and HS edges in DELAY restart the row count
        fs_pulse();
        repeat (10) hs_pulse();
        FSb = 1'b0; HSb = 1'b0;
        tick();
        FSb = 1'b1; HSb = 1'b1;
        tick();
        repeat (23) hs_pulse();
        chk("t3_clk_en_23", 32'(CLK_EN), 1);
        hs_pulse();
        chk("t3_clk_en_24", 32'(CLK_EN), 0);
        pad_run(-1, cyc, bad);
        chk("t3_pad_cycles", 32'(cyc), 5675);

        // 4: FS edge during padding sets sticky overrun
        fs_pulse();
        repeat (24) hs_pulse();
        pad_run(5 * 227 + 10, cyc, bad);
        chk("t4_pad_cycles", 32'(cyc), 5675);
        chk("t4_pattern_bad", 32'(bad), 0);
        chk("t4_overrun", 32'(OVERRUN), 1);
        step(5);
        chk("t4_overrun_held", 32'(OVERRUN), 1);
        chk("t4_clk_en_idle", 32'(CLK_EN), 1);

        // 5: switch to NTSC mid-padding
        fs_pulse();
        repeat (24) hs_pulse();
        step(12 * 227 + 100);
        chk("t5_pad_line_12", 32'(PAD_LINE), 12);
        chk("t5_clk_en_mid", 32'(CLK_EN), 0);
        Format = 1'b1;
        tick();
        chk("t5_abort_clk_en", 32'(CLK_EN), 1);
        chk("t5_abort_pad_hs", 32'(PAD_HS), 0);
        chk("t5_abort_luma", 32'(LUMA_BLANK), 0);
        chk("t5_abort_pad_line", 32'(PAD_LINE), 0);
        Format = 1'b0;
        tick();
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            hs_pulse();
            if (CLK_EN !== 1'b1) bad++;
        end
        chk("t5_no_pad_without_fs", 32'(bad), 0);
        fs_pulse();
        repeat (23) hs_pulse();
        chk("t5_clk_en_23", 32'(CLK_EN), 1);
        hs_pulse();
        chk("t5_clk_en_24", 32'(CLK_EN), 0);
        chk("t5_overrun_held", 32'(OVERRUN), 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("t5_rst_clk_en", 32'(CLK_EN), 1);
        chk("t5_rst_luma", 32'(LUMA_BLANK), 0);
        chk("t5_rst_overrun", 32'(OVERRUN), 0);

        // 6: short-parameter instance
        fs6 = 1'b0;
        tick();
        fs6 = 1'b1;
        chk("t6_clk_en_detect", 32'(clk_en6), 1);
        tick();
        chk("t6_clk_en_start", 32'(clk_en6), 0);
        cyc = 0;
        hs_cnt = 0;
        while (clk_en6 === 1'b0 && cyc < 100) begin
            if (pad_hs6 === 1'b1 && cyc < 3) hs_cnt++;
            if (pad_hs6 === 1'b1 && cyc >= 3) hs_cnt += 100;
            cyc++;
            tick();
        end
        chk("t6_pad_cycles", 32'(cyc), 20);
        chk("t6_pad_hs_cycles", 32'(hs_cnt), 3);
        fs6 = 1'b0;
        tick();
        fs6 = 1'b1;
        tick();
        step(10);
        chk("t6_clk_en_mid", 32'(clk_en6), 0);
        rst6 = 1'b1;
        tick();
        rst6 = 1'b0;
        chk("t6_rst_clk_en", 32'(clk_en6), 1);
        chk("t6_rst_pad_hs", 32'(pad_hs6), 0);
        chk("t6_rst_luma", 32'(luma6), 0);
        chk("t6_rst_pad_line", 32'(pad_line6), 0);
        chk("t6_rst_overrun", 32'(ovr6), 0);
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (clk_en6 !== 1'b1) bad++;
        end
        chk("t6_idle_after_rst", 32'(bad), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
